// File: rtl/disp_layer_sched.sv
// ---------------------------------------------------------------------------
// disp_layer_sched
//
// Layer scheduler for the VGA output path (clk_vga domain). Arbitrates five
// per-pixel layer requests (0 me, 1 bullet, 2 enemy, 3 bonus, 4 info) under a
// software-loadable priority order and enable mask, and drives the winning
// colour through a 2-stage pipeline. New configurations are staged in pending
// registers and only become active on a frame_end_i pulse, so a frame is
// never rendered with mixed settings.
//
// Optional feature macro: LAYER_BLINK_EN
//   defined   : info layer is additionally gated by frame_cnt_o[3]
//               (visible 8 frames, hidden 8 frames)
//   undefined : info layer depends only on its alpha and enable
//
// Ports:
//   clk_vga, rst             pixel clock, async active-high reset
//   disp_i                   pixel is in the visible area
//   frame_end_i              one-cycle pulse at start of vertical blanking
//   *_rgb_i, *_alpha_i       per-layer colour and opaque flag
//   cfg_valid_i/cfg_ready_o  configuration handshake
//   cfg_order_i              slot k = [3k+2:3k] = layer index, slot 0 highest
//   cfg_en_i                 per-layer enable (bit = layer index)
//   cfg_bg_i                 background colour
//   cfg_err_o                one-cycle pulse: rejected configuration
//   rgb_o, layer_o           composited pixel, winner (5 = bg, 6 = blanked)
//   frame_cnt_o              frames since reset (wraps)
//   dbg_cfg_state_o          config FSM state (0 = IDLE, 1 = PEND)
//
// Handshake: a configuration transfers on any cycle where cfg_valid_i and
// cfg_ready_o are both high. Invalid offers are still consumed (ready stays
// high) and answered with cfg_err_o one cycle later.
// ---------------------------------------------------------------------------
module disp_layer_sched #(
  parameter int RGB_W  = 12,
  parameter int FCNT_W = 6
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic              disp_i,
  input  logic              frame_end_i,
  input  logic [RGB_W-1:0]  me_rgb_i,
  input  logic [RGB_W-1:0]  bullet_rgb_i,
  input  logic [RGB_W-1:0]  enemy_rgb_i,
  input  logic [RGB_W-1:0]  bonus_rgb_i,
  input  logic [RGB_W-1:0]  info_rgb_i,
  input  logic              me_alpha_i,
  input  logic              bullet_alpha_i,
  input  logic              enemy_alpha_i,
  input  logic              bonus_alpha_i,
  input  logic              info_alpha_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [14:0]       cfg_order_i,
  input  logic [4:0]        cfg_en_i,
  input  logic [RGB_W-1:0]  cfg_bg_i,
  output logic              cfg_err_o,
  output logic [RGB_W-1:0]  rgb_o,
  output logic [2:0]        layer_o,
  output logic [FCNT_W-1:0] frame_cnt_o,
  output logic              dbg_cfg_state_o
);

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

  localparam logic [14:0] ORDER_RST = 15'b000_100_011_010_001;

  // Config state
  cfg_state_t          state_q, state_d;
  logic [14:0]         pend_order_q, pend_order_d;
  logic [4:0]          pend_en_q, pend_en_d;
  logic [RGB_W-1:0]    pend_bg_q, pend_bg_d;
  logic [14:0]         act_order_q, act_order_d;
  logic [4:0]          act_en_q, act_en_d;
  logic [RGB_W-1:0]    act_bg_q, act_bg_d;
  logic                cfg_err_q, cfg_err_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  // Pipeline state
  logic                disp_s1_q, disp_s1_d;
  logic [4:0]          alpha_s1_q, alpha_s1_d;
  logic [RGB_W-1:0]    me_s1_q, me_s1_d;
  logic [RGB_W-1:0]    bullet_s1_q, bullet_s1_d;
  logic [RGB_W-1:0]    enemy_s1_q, enemy_s1_d;
  logic [RGB_W-1:0]    bonus_s1_q, bonus_s1_d;
  logic [RGB_W-1:0]    info_s1_q, info_s1_d;
  logic [RGB_W-1:0]    rgb_q, rgb_d;
  logic [2:0]          layer_q, layer_d;

  // Order validation: every slot in 0..4 and all five indices present.
  // With five slots, "all five present" implies distinct.
  logic [4:0] seen;
  logic [2:0] chk_slot;
  logic       cfg_ok;

  always_comb begin
    seen     = 5'h00;
    chk_slot = 3'd0;
    for (int k = 0; k < 5; k++) begin
      chk_slot = cfg_order_i[3*k +: 3];
      if (chk_slot <= 3'd4) seen[chk_slot] = 1'b1;
    end
    cfg_ok = (seen == 5'h1F);
  end

  // Config FSM and frame counter
  always_comb begin
    state_d      = state_q;
    pend_order_d = pend_order_q;
    pend_en_d    = pend_en_q;
    pend_bg_d    = pend_bg_q;
    act_order_d  = act_order_q;
    act_en_d     = act_en_q;
    act_bg_d     = act_bg_q;
    cfg_err_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (frame_end_i) frame_cnt_d = frame_cnt_q + 1'b1;

    case (state_q)
      CFG_IDLE: begin
        // An accept on a frame_end_i cycle lands in PEND only after this
        // edge, so it waits for the following frame_end_i to commit.
        if (cfg_valid_i) begin
          if (cfg_ok) begin
            pend_order_d = cfg_order_i;
            pend_en_d    = cfg_en_i;
            pend_bg_d    = cfg_bg_i;
            state_d      = CFG_PEND;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      CFG_PEND: begin
        if (frame_end_i) begin
          act_order_d = pend_order_q;
          act_en_d    = pend_en_q;
          act_bg_d    = pend_bg_q;
          state_d     = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  // Stage 1: register pixel inputs with enable-masked alphas
  always_comb begin
    disp_s1_d     = disp_i;
    me_s1_d       = me_rgb_i;
    bullet_s1_d   = bullet_rgb_i;
    enemy_s1_d    = enemy_rgb_i;
    bonus_s1_d    = bonus_rgb_i;
    info_s1_d     = info_rgb_i;
    alpha_s1_d    = {info_alpha_i, bonus_alpha_i, enemy_alpha_i,
                     bullet_alpha_i, me_alpha_i} & act_en_q;
`ifdef LAYER_BLINK_EN
    alpha_s1_d[4] = alpha_s1_d[4] & frame_cnt_q[3];
`else
    alpha_s1_d[4] = alpha_s1_d[4];
`endif
  end

  // Stage 2: priority scan. Walking from slot 4 down to slot 0 lets the
  // highest-priority opaque layer overwrite any lower one.
  logic [2:0] scan_slot;
  logic [2:0] win_idx;
  logic       win_found;

  always_comb begin
    scan_slot = 3'd0;
    win_idx   = 3'd5;
    win_found = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      scan_slot = act_order_q[3*k +: 3];
      if (scan_slot <= 3'd4 && alpha_s1_q[scan_slot]) begin
        win_idx   = scan_slot;
        win_found = 1'b1;
      end
    end

    rgb_d   = act_bg_q;
    layer_d = 3'd5;
    if (!disp_s1_q) begin
      rgb_d   = '0;
      layer_d = 3'd6;
    end else if (win_found) begin
      layer_d = win_idx;
      case (win_idx)
        3'd0:    rgb_d = me_s1_q;
        3'd1:    rgb_d = bullet_s1_q;
        3'd2:    rgb_d = enemy_s1_q;
        3'd3:    rgb_d = bonus_s1_q;
        3'd4:    rgb_d = info_s1_q;
        default: rgb_d = act_bg_q;
      endcase
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q      <= CFG_IDLE;
      pend_order_q <= ORDER_RST;
      pend_en_q    <= 5'h1F;
      pend_bg_q    <= '0;
      act_order_q  <= ORDER_RST;
      act_en_q     <= 5'h1F;
      act_bg_q     <= '0;
      cfg_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
      disp_s1_q    <= 1'b0;
      alpha_s1_q   <= 5'h00;
      me_s1_q      <= '0;
      bullet_s1_q  <= '0;
      enemy_s1_q   <= '0;
      bonus_s1_q   <= '0;
      info_s1_q    <= '0;
      rgb_q        <= '0;
      layer_q      <= 3'd6;
    end else begin
      state_q      <= state_d;
      pend_order_q <= pend_order_d;
      pend_en_q    <= pend_en_d;
      pend_bg_q    <= pend_bg_d;
      act_order_q  <= act_order_d;
      act_en_q     <= act_en_d;
      act_bg_q     <= act_bg_d;
      cfg_err_q    <= cfg_err_d;
      frame_cnt_q  <= frame_cnt_d;
      disp_s1_q    <= disp_s1_d;
      alpha_s1_q   <= alpha_s1_d;
      me_s1_q      <= me_s1_d;
      bullet_s1_q  <= bullet_s1_d;
      enemy_s1_q   <= enemy_s1_d;
      bonus_s1_q   <= bonus_s1_d;
      info_s1_q    <= info_s1_d;
      rgb_q        <= rgb_d;
      layer_q      <= layer_d;
    end
  end

  assign cfg_ready_o     = (state_q == CFG_IDLE);
  assign cfg_err_o       = cfg_err_q;
  assign rgb_o           = rgb_q;
  assign layer_o         = layer_q;
  assign frame_cnt_o     = frame_cnt_q;
  assign dbg_cfg_state_o = state_q;

endmodule

// File: tb/tb_disp_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_disp_layer_sched
//
// Directed bench for disp_layer_sched: reset values, priority selection,
// frame-synchronised config commit, rejected config, background/blanking,
// accept coinciding with frame_end, enable mask, frame counter wrap, and the
// info blink (LAYER_BLINK_EN) behaviour.
// ---------------------------------------------------------------------------
module tb_disp_layer_sched;

  localparam int RGB_W  = 12;
  localparam int FCNT_W = 6;

  logic              clk_vga;
  logic              rst;
  logic              disp_i;
  logic              frame_end_i;
  logic [RGB_W-1:0]  me_rgb_i, bullet_rgb_i, enemy_rgb_i, bonus_rgb_i, info_rgb_i;
  logic              me_alpha_i, bullet_alpha_i, enemy_alpha_i, bonus_alpha_i, info_alpha_i;
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [14:0]       cfg_order_i;
  logic [4:0]        cfg_en_i;
  logic [RGB_W-1:0]  cfg_bg_i;
  logic              cfg_err_o;
  logic [RGB_W-1:0]  rgb_o;
  logic [2:0]        layer_o;
  logic [FCNT_W-1:0] frame_cnt_o;
  logic              dbg_cfg_state_o;

  int tests_run;
  int tests_failed;
  logic [FCNT_W-1:0] exp_fcnt;

  disp_layer_sched #(.RGB_W(RGB_W), .FCNT_W(FCNT_W)) dut (
    .clk_vga         (clk_vga),
    .rst             (rst),
    .disp_i          (disp_i),
    .frame_end_i     (frame_end_i),
    .me_rgb_i        (me_rgb_i),
    .bullet_rgb_i    (bullet_rgb_i),
    .enemy_rgb_i     (enemy_rgb_i),
    .bonus_rgb_i     (bonus_rgb_i),
    .info_rgb_i      (info_rgb_i),
    .me_alpha_i      (me_alpha_i),
    .bullet_alpha_i  (bullet_alpha_i),
    .enemy_alpha_i   (enemy_alpha_i),
    .bonus_alpha_i   (bonus_alpha_i),
    .info_alpha_i    (info_alpha_i),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .cfg_order_i     (cfg_order_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_bg_i        (cfg_bg_i),
    .cfg_err_o       (cfg_err_o),
    .rgb_o           (rgb_o),
    .layer_o         (layer_o),
    .frame_cnt_o     (frame_cnt_o),
    .dbg_cfg_state_o (dbg_cfg_state_o)
  );

  // Clock / reset
  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  // Driver tasks: inputs change and outputs are sampled 1 time unit after
  // the rising edge.
  task automatic step();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic clear_alpha();
    me_alpha_i = 0; bullet_alpha_i = 0; enemy_alpha_i = 0;
    bonus_alpha_i = 0; info_alpha_i = 0;
  endtask

  task automatic pulse_frame_end();
    frame_end_i = 1'b1;
    step();
    frame_end_i = 1'b0;
    exp_fcnt = exp_fcnt + 1'b1;
  endtask

  task automatic offer_cfg(input logic [14:0] order, input logic [4:0] en,
                           input logic [RGB_W-1:0] bg);
    cfg_valid_i = 1'b1; cfg_order_i = order; cfg_en_i = en; cfg_bg_i = bg;
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    tests_run++; if (cfg_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", cfg_ready_o); end
    tests_run++; if (cfg_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", cfg_err_o); end
    tests_run++; if (rgb_o !== 12'h000) begin tests_failed++; $display("FAIL reset_rgb got %h want 000", rgb_o); end
    tests_run++; if (layer_o !== 3'd6) begin tests_failed++; $display("FAIL reset_layer got %0d want 6", layer_o); end
    tests_run++; if (frame_cnt_o !== 6'd0) begin tests_failed++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt_o); end
    rst = 1'b0;
    step();
  endtask

  // Default order {1,2,3,4,0}: bullet > enemy > bonus > info > me
  task automatic test_default_priority();
    disp_i = 1'b1;
    me_rgb_i = 12'hABC; bullet_rgb_i = 12'h0F0; enemy_rgb_i = 12'h00E;
    bonus_rgb_i = 12'hB0B; info_rgb_i = 12'hF00;
    clear_alpha(); enemy_alpha_i = 1; info_alpha_i = 1;
    step(); step();
    tests_run++; if (rgb_o !== 12'h00E || layer_o !== 3'd2) begin tests_failed++; $display("FAIL prio_enemy got %h/%0d want 00E/2", rgb_o, layer_o); end
    clear_alpha(); me_alpha_i = 1; bullet_alpha_i = 1;
    step(); step();
    tests_run++; if (rgb_o !== 12'h0F0 || layer_o !== 3'd1) begin tests_failed++; $display("FAIL prio_bullet got %h/%0d want 0F0/1", rgb_o, layer_o); end
  endtask

  // Order {0,1,2,3,4} = 15'h4688, bg 123
  task automatic test_cfg_commit();
    offer_cfg(15'h4688, 5'h1F, 12'h123);
    tests_run++; if (cfg_ready_o !== 1'b0) begin tests_failed++; $display("FAIL commit_ready_drop got %b want 0", cfg_ready_o); end
    step(); step();
    tests_run++; if (rgb_o !== 12'h0F0 || layer_o !== 3'd1) begin tests_failed++; $display("FAIL commit_before_fe got %h/%0d want 0F0/1", rgb_o, layer_o); end
    pulse_frame_end();
    tests_run++; if (cfg_ready_o !== 1'b1) begin tests_failed++; $display("FAIL commit_ready_rise got %b want 1", cfg_ready_o); end
    tests_run++; if (frame_cnt_o !== exp_fcnt) begin tests_failed++; $display("FAIL commit_fcnt got %0d want %0d", frame_cnt_o, exp_fcnt); end
    step(); step();
    tests_run++; if (rgb_o !== 12'hABC || layer_o !== 3'd0) begin tests_failed++; $display("FAIL commit_after_fe got %h/%0d want ABC/0", rgb_o, layer_o); end
  endtask

  // 15'h0492 holds slot values 2,2,2,2,0: duplicate, rejected
  task automatic test_cfg_err();
    offer_cfg(15'h0492, 5'h1F, 12'hFFF);
    tests_run++; if (cfg_err_o !== 1'b1) begin tests_failed++; $display("FAIL err_pulse got %b want 1", cfg_err_o); end
    tests_run++; if (cfg_ready_o !== 1'b1) begin tests_failed++; $display("FAIL err_ready got %b want 1", cfg_ready_o); end
    step();
    tests_run++; if (cfg_err_o !== 1'b0) begin tests_failed++; $display("FAIL err_once got %b want 0", cfg_err_o); end
    pulse_frame_end();
    step(); step();
    tests_run++; if (rgb_o !== 12'hABC || layer_o !== 3'd0) begin tests_failed++; $display("FAIL err_active_kept got %h/%0d want ABC/0", rgb_o, layer_o); end
    // Slot value 7 is out of range
    offer_cfg(15'h7688, 5'h1F, 12'hFFF);
    tests_run++; if (cfg_err_o !== 1'b1) begin tests_failed++; $display("FAIL err_range got %b want 1", cfg_err_o); end
    step();
  endtask

  task automatic test_background();
    clear_alpha(); disp_i = 1'b1;
    step(); step();
    tests_run++; if (rgb_o !== 12'h123 || layer_o !== 3'd5) begin tests_failed++; $display("FAIL bg got %h/%0d want 123/5", rgb_o, layer_o); end
    me_alpha_i = 1; disp_i = 1'b0;
    step(); step();
    tests_run++; if (rgb_o !== 12'h000 || layer_o !== 3'd6) begin tests_failed++; $display("FAIL blank got %h/%0d want 000/6", rgb_o, layer_o); end
    disp_i = 1'b1;
  endtask

  // Order {4,3,2,1,0} = 15'h029C accepted on a frame_end cycle
  task automatic test_same_cycle_accept();
    clear_alpha(); me_alpha_i = 1; bonus_alpha_i = 1; disp_i = 1'b1;
    cfg_valid_i = 1'b1; cfg_order_i = 15'h029C; cfg_en_i = 5'h1F; cfg_bg_i = 12'h456;
    frame_end_i = 1'b1;
    step();
    cfg_valid_i = 1'b0; frame_end_i = 1'b0; exp_fcnt = exp_fcnt + 1'b1;
    tests_run++; if (cfg_ready_o !== 1'b0) begin tests_failed++; $display("FAIL same_ready got %b want 0", cfg_ready_o); end
    tests_run++; if (frame_cnt_o !== exp_fcnt) begin tests_failed++; $display("FAIL same_fcnt got %0d want %0d", frame_cnt_o, exp_fcnt); end
    step(); step();
    tests_run++; if (rgb_o !== 12'hABC || layer_o !== 3'd0) begin tests_failed++; $display("FAIL same_not_applied got %h/%0d want ABC/0", rgb_o, layer_o); end
    pulse_frame_end();
    tests_run++; if (cfg_ready_o !== 1'b1) begin tests_failed++; $display("FAIL same_ready_rise got %b want 1", cfg_ready_o); end
    step(); step();
    tests_run++; if (rgb_o !== 12'hB0B || layer_o !== 3'd3) begin tests_failed++; $display("FAIL same_applied got %h/%0d want B0B/3", rgb_o, layer_o); end
  endtask

  // Order {0,1,2,3,4} with me disabled, bg 789
  task automatic test_enable_mask();
    offer_cfg(15'h4688, 5'h1E, 12'h789);
    pulse_frame_end();
    clear_alpha(); me_alpha_i = 1; bullet_alpha_i = 1;
    step(); step();
    tests_run++; if (rgb_o !== 12'h0F0 || layer_o !== 3'd1) begin tests_failed++; $display("FAIL en_mask got %h/%0d want 0F0/1", rgb_o, layer_o); end
    clear_alpha(); me_alpha_i = 1;
    step(); step();
    tests_run++; if (rgb_o !== 12'h789 || layer_o !== 3'd5) begin tests_failed++; $display("FAIL en_mask_bg got %h/%0d want 789/5", rgb_o, layer_o); end
  endtask

  task automatic test_frame_wrap();
    while (exp_fcnt != 6'd63) pulse_frame_end();
    tests_run++; if (frame_cnt_o !== 6'd63) begin tests_failed++; $display("FAIL fcnt_max got %0d want 63", frame_cnt_o); end
    pulse_frame_end();
    tests_run++; if (frame_cnt_o !== 6'd0) begin tests_failed++; $display("FAIL fcnt_wrap got %0d want 0", frame_cnt_o); end
  endtask

  task automatic test_blink();
    logic [RGB_W-1:0] exp_rgb;
    logic [2:0]       exp_layer;
    clear_alpha(); info_alpha_i = 1; disp_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      step(); step();
`ifdef LAYER_BLINK_EN
      exp_rgb   = exp_fcnt[3] ? 12'hF00 : 12'h789;
      exp_layer = exp_fcnt[3] ? 3'd4 : 3'd5;
`else
      exp_rgb   = 12'hF00;
      exp_layer = 3'd4;
`endif
      tests_run++; if (rgb_o !== exp_rgb || layer_o !== exp_layer) begin tests_failed++; $display("FAIL blink_fcnt%0d got %h/%0d want %h/%0d", exp_fcnt, rgb_o, layer_o, exp_rgb, exp_layer); end
      repeat (8) pulse_frame_end();
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; exp_fcnt = '0;
    rst = 1'b1; disp_i = 0; frame_end_i = 0;
    me_rgb_i = '0; bullet_rgb_i = '0; enemy_rgb_i = '0; bonus_rgb_i = '0; info_rgb_i = '0;
    me_alpha_i = 0; bullet_alpha_i = 0; enemy_alpha_i = 0; bonus_alpha_i = 0; info_alpha_i = 0;
    cfg_valid_i = 0; cfg_order_i = '0; cfg_en_i = '0; cfg_bg_i = '0;

    test_reset();
    test_default_priority();
    test_cfg_commit();
    test_cfg_err();
    test_background();
    test_same_cycle_accept();
    test_enable_mask();
    test_frame_wrap();
    test_blink();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
